// File: rtl/umi_arb_pkg.sv
// Shared types and helpers for the UMI requester arbiter: state encoding,
// command-field decode and the round-robin pick function.
package umi_arb_pkg;

  localparam int unsigned MAX_N   = 8;
  localparam int unsigned MAX_IW  = 3;
  localparam int unsigned OPC_W   = 5;
  localparam int unsigned OPC_LSB = 0;
  localparam int unsigned EOM_BIT = 22;

  localparam logic [OPC_W-1:0] UMI_REQ_READ  = 5'h01;
  localparam logic [OPC_W-1:0] UMI_REQ_WRITE = 5'h03;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic              found;
    logic [MAX_IW-1:0] idx;
  } rr_sel_t;

  // Read and write requests are answered; posted writes are not.
  function automatic logic needs_resp(input logic [OPC_W-1:0] opcode);
    return (opcode == UMI_REQ_READ) || (opcode == UMI_REQ_WRITE);
  endfunction

  // First valid requester at or after ptr, wrapping within n entries.
  function automatic rr_sel_t rr_select(input logic [MAX_N-1:0]  valid,
                                        input logic [MAX_IW-1:0] ptr,
                                        input int unsigned       n);
    rr_sel_t     r;
    int unsigned j;
    r = '0;
    for (int unsigned k = 0; k < MAX_N; k++) begin
      j = 32'(ptr) + k;
      if (j >= n) j = j - n;
      if (!r.found && (k < n) && valid[j[MAX_IW-1:0]]) begin
        r.found = 1'b1;
        r.idx   = j[MAX_IW-1:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/umi_gpio_arbiter_if.sv
// Bus bundle between the host-side UMI requesters, the arbiter and the device.
interface umi_gpio_arbiter_if #(
  parameter int unsigned N  = 2,
  parameter int unsigned DW = 256,
  parameter int unsigned AW = 64,
  parameter int unsigned CW = 32
);

  logic [N-1:0]    host_req_valid;
  logic [N*CW-1:0] host_req_cmd;
  logic [N*AW-1:0] host_req_dstaddr;
  logic [N*AW-1:0] host_req_srcaddr;
  logic [N*DW-1:0] host_req_data;
  logic [N-1:0]    host_req_ready;

  logic [N-1:0]    host_resp_valid;
  logic [CW-1:0]   host_resp_cmd;
  logic [AW-1:0]   host_resp_dstaddr;
  logic [AW-1:0]   host_resp_srcaddr;
  logic [DW-1:0]   host_resp_data;
  logic [N-1:0]    host_resp_ready;

  logic            dev_req_valid;
  logic [CW-1:0]   dev_req_cmd;
  logic [AW-1:0]   dev_req_dstaddr;
  logic [AW-1:0]   dev_req_srcaddr;
  logic [DW-1:0]   dev_req_data;
  logic            dev_req_ready;

  logic            dev_resp_valid;
  logic [CW-1:0]   dev_resp_cmd;
  logic [AW-1:0]   dev_resp_dstaddr;
  logic [AW-1:0]   dev_resp_srcaddr;
  logic [DW-1:0]   dev_resp_data;
  logic            dev_resp_ready;

  // Arbiter view.
  modport slave (
    input  host_req_valid, host_req_cmd, host_req_dstaddr, host_req_srcaddr, host_req_data,
    output host_req_ready,
    output host_resp_valid, host_resp_cmd, host_resp_dstaddr, host_resp_srcaddr, host_resp_data,
    input  host_resp_ready,
    output dev_req_valid, dev_req_cmd, dev_req_dstaddr, dev_req_srcaddr, dev_req_data,
    input  dev_req_ready,
    input  dev_resp_valid, dev_resp_cmd, dev_resp_dstaddr, dev_resp_srcaddr, dev_resp_data,
    output dev_resp_ready
  );

  // Environment view (requesters plus device).
  modport master (
    output host_req_valid, host_req_cmd, host_req_dstaddr, host_req_srcaddr, host_req_data,
    input  host_req_ready,
    input  host_resp_valid, host_resp_cmd, host_resp_dstaddr, host_resp_srcaddr, host_resp_data,
    output host_resp_ready,
    input  dev_req_valid, dev_req_cmd, dev_req_dstaddr, dev_req_srcaddr, dev_req_data,
    output dev_req_ready,
    output dev_resp_valid, dev_resp_cmd, dev_resp_dstaddr, dev_resp_srcaddr, dev_resp_data,
    input  dev_resp_ready
  );

endinterface

// File: rtl/umi_rr_select.sv
// Combinational round-robin picker: valid vector + pointer in, one-hot grant
// and binary index out.
module umi_rr_select
  import umi_arb_pkg::*;
#(
  parameter  int unsigned N  = 2,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          found
);

  rr_sel_t sel_c;

  always_comb begin
    sel_c = rr_select(MAX_N'(valid), MAX_IW'(ptr), N);
    found = sel_c.found;
    grant = '0;
    idx   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      grant[i] = sel_c.found && (sel_c.idx == MAX_IW'(i));
      if (grant[i]) idx = IW'(i);
    end
  end

endmodule

// File: rtl/umi_gpio_arbiter.sv
// Round-robin arbiter sharing one UMI device port among N requesters, one
// transaction in flight. Optional response timeout: UMI_GPIO_ARB_TIMEOUT_EN.
module umi_gpio_arbiter
  import umi_arb_pkg::*;
#(
  parameter  int unsigned N       = 2,
  parameter  int unsigned DW      = 256,
  parameter  int unsigned AW      = 64,
  parameter  int unsigned CW      = 32,
`ifdef UMI_GPIO_ARB_TIMEOUT_EN
  parameter  int unsigned TIMEOUT = 1024,
`endif
  localparam int unsigned IW      = $clog2(N)
) (
  input  logic                clk,
  input  logic                rst,
  umi_gpio_arbiter_if.slave   bus,
  output logic [IW-1:0]       owner,
`ifdef UMI_GPIO_ARB_TIMEOUT_EN
  output logic                busy,
  output logic                timeout_err
`else
  output logic                busy
`endif
);

  arb_state_t    state, state_nxt;
  logic [IW-1:0] owner_nxt;
  logic [IW-1:0] rr_ptr, rr_ptr_nxt;
  logic          resp_exp, resp_exp_nxt;

  logic [N-1:0]  rr_grant;
  logic [IW-1:0] rr_idx;
  logic          rr_found;
  logic [IW-1:0] cur;

  logic          req_fire, req_eom, resp_fire, resp_eom;
  logic [OPC_W-1:0] req_opc;

  function automatic logic [IW-1:0] rr_next(input logic [IW-1:0] x);
    return (x == IW'(N - 1)) ? '0 : x + IW'(1);
  endfunction

  umi_rr_select #(.N(N)) u_rr_select (
    .valid (bus.host_req_valid),
    .ptr   (rr_ptr),
    .grant (rr_grant),
    .idx   (rr_idx),
    .found (rr_found)
  );

  assign req_fire  = bus.dev_req_valid && bus.dev_req_ready;
  assign req_eom   = bus.dev_req_cmd[EOM_BIT];
  assign req_opc   = bus.dev_req_cmd[OPC_LSB +: OPC_W];
  assign resp_fire = bus.dev_resp_valid && bus.dev_resp_ready;
  assign resp_eom  = bus.dev_resp_cmd[EOM_BIT];
  assign busy      = (state != ST_IDLE);

  // Response payload is broadcast; only the valid bit is steered.
  assign bus.host_resp_cmd     = bus.dev_resp_cmd;
  assign bus.host_resp_dstaddr = bus.dev_resp_dstaddr;
  assign bus.host_resp_srcaddr = bus.dev_resp_srcaddr;
  assign bus.host_resp_data    = bus.dev_resp_data;

`ifdef UMI_GPIO_ARB_TIMEOUT_EN
  logic [31:0] wait_cnt;
  logic        timeout_hit;

  assign timeout_hit = (state == ST_WAIT) && !(resp_fire && resp_eom) &&
                       (wait_cnt == 32'(TIMEOUT - 1));

  // Counts WAIT cycles; a hit forces IDLE and emits a one-cycle error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= timeout_hit;
      if (state != ST_WAIT) wait_cnt <= '0;
      else                  wait_cnt <= wait_cnt + 32'd1;
    end
  end
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      owner    <= '0;
      rr_ptr   <= '0;
      resp_exp <= 1'b0;
    end else begin
      state    <= state_nxt;
      owner    <= owner_nxt;
      rr_ptr   <= rr_ptr_nxt;
      resp_exp <= resp_exp_nxt;
    end
  end

  // Next-state logic; the pointer moves once the last request flit is taken.
  always_comb begin
    state_nxt    = state;
    owner_nxt    = owner;
    rr_ptr_nxt   = rr_ptr;
    resp_exp_nxt = resp_exp;
    case (state)
      ST_IDLE: begin
        if (req_fire) begin
          if (!req_eom) begin
            state_nxt    = ST_REQ;
            owner_nxt    = rr_idx;
            resp_exp_nxt = needs_resp(req_opc);
          end else begin
            rr_ptr_nxt = rr_next(rr_idx);
            if (needs_resp(req_opc)) begin
              state_nxt = ST_WAIT;
              owner_nxt = rr_idx;
            end
          end
        end
      end
      ST_REQ: begin
        if (req_fire && req_eom) begin
          rr_ptr_nxt = rr_next(owner);
          state_nxt  = resp_exp ? ST_WAIT : ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (resp_fire && resp_eom) begin
          state_nxt = ST_IDLE;
        end
`ifdef UMI_GPIO_ARB_TIMEOUT_EN
        else if (timeout_hit) begin
          state_nxt  = ST_IDLE;
          rr_ptr_nxt = rr_next(owner);
        end
`endif
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output logic: request mux toward the device, ready/valid steering.
  always_comb begin
    bus.dev_req_valid   = 1'b0;
    bus.dev_req_cmd     = '0;
    bus.dev_req_dstaddr = '0;
    bus.dev_req_srcaddr = '0;
    bus.dev_req_data    = '0;
    bus.host_req_ready  = '0;
    bus.host_resp_valid = '0;
    bus.dev_resp_ready  = 1'b0;

    cur = (state == ST_IDLE) ? rr_idx : owner;
    for (int unsigned i = 0; i < N; i++) begin
      if (IW'(i) == cur) begin
        bus.dev_req_cmd     = bus.host_req_cmd[i*CW +: CW];
        bus.dev_req_dstaddr = bus.host_req_dstaddr[i*AW +: AW];
        bus.dev_req_srcaddr = bus.host_req_srcaddr[i*AW +: AW];
        bus.dev_req_data    = bus.host_req_data[i*DW +: DW];
      end
    end

    case (state)
      ST_IDLE: begin
        bus.dev_req_valid  = rr_found;
        bus.host_req_ready = rr_grant & {N{bus.dev_req_ready}};
`ifdef UMI_GPIO_ARB_TIMEOUT_EN
        // Drain any response arriving after a timeout.
        bus.dev_resp_ready = 1'b1;
`endif
      end
      ST_REQ: begin
        bus.dev_req_valid         = bus.host_req_valid[owner];
        bus.host_req_ready[owner] = bus.dev_req_ready;
      end
      ST_WAIT: begin
        bus.host_resp_valid[owner] = bus.dev_resp_valid;
        bus.dev_resp_ready         = bus.host_resp_ready[owner];
      end
      default: ;
    endcase

    if (rst) begin
      bus.dev_req_valid   = 1'b0;
      bus.host_req_ready  = '0;
      bus.host_resp_valid = '0;
      bus.dev_resp_ready  = 1'b0;
    end
  end

endmodule

// File: tb/tb_umi_gpio_arbiter.sv
// Directed bench for umi_gpio_arbiter (N=2); the timeout section runs only
// when UMI_GPIO_ARB_TIMEOUT_EN is defined.
module tb_umi_gpio_arbiter;

  localparam int unsigned N  = 2;
  localparam int unsigned DW = 256;
  localparam int unsigned AW = 64;
  localparam int unsigned CW = 32;

  localparam logic [4:0] OP_RD  = 5'h01;
  localparam logic [4:0] OP_WR  = 5'h03;
  localparam logic [4:0] OP_PW  = 5'h05;
  localparam logic [4:0] OP_RRD = 5'h02;
  localparam logic [4:0] OP_RWR = 5'h04;

`ifdef UMI_GPIO_ARB_TIMEOUT_EN
  localparam logic IDLE_RESP_RDY = 1'b1;
`else
  localparam logic IDLE_RESP_RDY = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic owner;
  logic busy;
`ifdef UMI_GPIO_ARB_TIMEOUT_EN
  logic timeout_err;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  umi_gpio_arbiter_if #(.N(N), .DW(DW), .AW(AW), .CW(CW)) u_if ();

  umi_gpio_arbiter #(
    .N(N), .DW(DW), .AW(AW), .CW(CW)
`ifdef UMI_GPIO_ARB_TIMEOUT_EN
    , .TIMEOUT(16)
`endif
  ) u_dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (u_if),
    .owner (owner),
`ifdef UMI_GPIO_ARB_TIMEOUT_EN
    .busy  (busy),
    .timeout_err (timeout_err)
`else
    .busy  (busy)
`endif
  );

  function automatic logic [31:0] mk_cmd(input logic [4:0] op, input logic [7:0] len,
                                         input logic [2:0] size, input logic eom);
    return {9'd0, eom, 6'd0, len, size, op};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [31:0] cmd, input logic [63:0] data);
    u_if.host_req_valid[i]         = v;
    u_if.host_req_cmd[i*CW +: CW]  = cmd;
    u_if.host_req_data[i*DW +: DW] = DW'(data);
  endtask

  task automatic to_neg();
    @(negedge clk);
  endtask

  task automatic to_pos();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst                   = 1'b1;
    u_if.host_req_valid   = '0;
    u_if.host_req_cmd     = '0;
    u_if.host_req_data    = '0;
    u_if.host_req_dstaddr = {64'h200, 64'h100};
    u_if.host_req_srcaddr = {64'h2000, 64'h1000};
    u_if.host_resp_ready  = 2'b11;
    u_if.dev_req_ready    = 1'b1;
    u_if.dev_resp_valid   = 1'b0;
    u_if.dev_resp_cmd     = '0;
    u_if.dev_resp_dstaddr = '0;
    u_if.dev_resp_srcaddr = '0;
    u_if.dev_resp_data    = '0;

    // Reset held with requests pending: everything stays quiet.
    set_req(0, 1'b1, mk_cmd(OP_PW, 8'd0, 3'd0, 1'b1), 64'h1111);
    set_req(1, 1'b1, mk_cmd(OP_PW, 8'd0, 3'd0, 1'b1), 64'h2222);
    repeat (2) @(posedge clk);
    to_neg();
    chk("rst_dreq_valid", 64'(u_if.dev_req_valid), 64'd0);
    chk("rst_hreq_ready", 64'(u_if.host_req_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_owner", 64'(owner), 64'd0);
    chk("rst_dresp_ready", 64'(u_if.dev_resp_ready), 64'd0);
    to_pos();
    rst = 1'b0;
    u_if.host_req_valid = '0;
    to_neg();
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_dreq_valid", 64'(u_if.dev_req_valid), 64'd0);
    chk("idle_dresp_ready", 64'(u_if.dev_resp_ready), 64'(IDLE_RESP_RDY));
    to_pos();

    // Two posted writes at once, ptr=0: requester 0 then requester 1.
    set_req(0, 1'b1, mk_cmd(OP_PW, 8'd0, 3'd0, 1'b1), 64'h1111);
    set_req(1, 1'b1, mk_cmd(OP_PW, 8'd0, 3'd0, 1'b1), 64'h2222);
    to_neg();
    chk("pw_ready0", 64'(u_if.host_req_ready), 64'b01);
    chk("pw_dvalid0", 64'(u_if.dev_req_valid), 64'd1);
    chk("pw_data0", u_if.dev_req_data[63:0], 64'h1111);
    chk("pw_dst0", u_if.dev_req_dstaddr, 64'h100);
    chk("pw_busy0", 64'(busy), 64'd0);
    to_pos();
    set_req(0, 1'b0, mk_cmd(OP_PW, 8'd0, 3'd0, 1'b1), 64'h1111);
    to_neg();
    chk("pw_ready1", 64'(u_if.host_req_ready), 64'b10);
    chk("pw_data1", u_if.dev_req_data[63:0], 64'h2222);
    chk("pw_busy1", 64'(busy), 64'd0);
    to_pos();
    set_req(1, 1'b0, mk_cmd(OP_PW, 8'd0, 3'd0, 1'b1), 64'h2222);
    to_neg();
    chk("pw_dvalid_end", 64'(u_if.dev_req_valid), 64'd0);
    to_pos();

    // 64-byte read by requester 1: two response flits routed to it alone.
    set_req(1, 1'b1, mk_cmd(OP_RD, 8'd63, 3'd0, 1'b1), 64'h0);
    to_neg();
    chk("rd_ready", 64'(u_if.host_req_ready), 64'b10);
    chk("rd_cmd", 64'(u_if.dev_req_cmd), 64'(mk_cmd(OP_RD, 8'd63, 3'd0, 1'b1)));
    to_pos();
    set_req(1, 1'b0, mk_cmd(OP_RD, 8'd63, 3'd0, 1'b1), 64'h0);
    u_if.dev_resp_valid = 1'b1;
    u_if.dev_resp_cmd   = mk_cmd(OP_RRD, 8'd31, 3'd0, 1'b0);
    u_if.dev_resp_data  = DW'(64'hC0C0);
    to_neg();
    chk("rd_busy", 64'(busy), 64'd1);
    chk("rd_owner", 64'(owner), 64'd1);
    chk("rd_hresp_valid0", 64'(u_if.host_resp_valid), 64'b10);
    chk("rd_dresp_ready0", 64'(u_if.dev_resp_ready), 64'd1);
    chk("rd_hresp_data0", u_if.host_resp_data[63:0], 64'hC0C0);
    to_pos();
    u_if.dev_resp_cmd  = mk_cmd(OP_RRD, 8'd31, 3'd0, 1'b1);
    u_if.dev_resp_data = DW'(64'hD0D0);
    to_neg();
    chk("rd_hresp_valid1", 64'(u_if.host_resp_valid), 64'b10);
    chk("rd_hresp_eom1", 64'(u_if.host_resp_cmd[22]), 64'd1);
    chk("rd_hresp_data1", u_if.host_resp_data[63:0], 64'hD0D0);
    to_pos();
    u_if.dev_resp_valid = 1'b0;
    to_neg();
    chk("rd_done_busy", 64'(busy), 64'd0);
    chk("rd_done_hresp", 64'(u_if.host_resp_valid), 64'b00);
    to_pos();

    // Write by 0 while 1 waits; owner's resp ready low for 10 cycles.
    set_req(0, 1'b1, mk_cmd(OP_WR, 8'd0, 3'd0, 1'b1), 64'h4444);
    set_req(1, 1'b1, mk_cmd(OP_PW, 8'd0, 3'd0, 1'b1), 64'h3333);
    to_neg();
    chk("wr_ready", 64'(u_if.host_req_ready), 64'b01);
    chk("wr_data", u_if.dev_req_data[63:0], 64'h4444);
    to_pos();
    set_req(0, 1'b0, mk_cmd(OP_WR, 8'd0, 3'd0, 1'b1), 64'h4444);
    u_if.dev_resp_valid  = 1'b1;
    u_if.dev_resp_cmd    = mk_cmd(OP_RWR, 8'd0, 3'd0, 1'b1);
    u_if.host_resp_ready = 2'b10;
    for (int c = 0; c < 10; c++) begin
      to_neg();
      chk($sformatf("stall_dresp_ready_%0d", c), 64'(u_if.dev_resp_ready), 64'd0);
      chk($sformatf("stall_hreq_ready_%0d", c), 64'(u_if.host_req_ready), 64'b00);
      chk($sformatf("stall_hresp_valid_%0d", c), 64'(u_if.host_resp_valid), 64'b01);
      to_pos();
    end
    u_if.host_resp_ready = 2'b11;
    to_neg();
    chk("wr_dresp_ready", 64'(u_if.dev_resp_ready), 64'd1);
    chk("wr_hresp_valid", 64'(u_if.host_resp_valid), 64'b01);
    to_pos();
    u_if.dev_resp_valid = 1'b0;
    to_neg();
    chk("wr_next_ready", 64'(u_if.host_req_ready), 64'b10);
    chk("wr_next_data", u_if.dev_req_data[63:0], 64'h3333);
    chk("wr_next_busy", 64'(busy), 64'd0);
    to_pos();
    set_req(1, 1'b0, mk_cmd(OP_PW, 8'd0, 3'd0, 1'b1), 64'h3333);

    // Round-robin order: after 0 is served, both valid -> 1 wins.
    set_req(0, 1'b1, mk_cmd(OP_PW, 8'd0, 3'd0, 1'b1), 64'h5555);
    to_neg();
    chk("rr_ready_a", 64'(u_if.host_req_ready), 64'b01);
    to_pos();
    set_req(1, 1'b1, mk_cmd(OP_PW, 8'd0, 3'd0, 1'b1), 64'h6666);
    to_neg();
    chk("rr_ready_b", 64'(u_if.host_req_ready), 64'b10);
    chk("rr_data_b", u_if.dev_req_data[63:0], 64'h6666);
    to_pos();
    set_req(1, 1'b0, mk_cmd(OP_PW, 8'd0, 3'd0, 1'b1), 64'h6666);
    to_neg();
    chk("rr_ready_c", 64'(u_if.host_req_ready), 64'b01);
    chk("rr_data_c", u_if.dev_req_data[63:0], 64'h5555);
    to_pos();
    set_req(0, 1'b0, mk_cmd(OP_PW, 8'd0, 3'd0, 1'b1), 64'h5555);

    // Requester 0 retracts before handshake; no lock, 1 is served next.
    u_if.dev_req_ready = 1'b0;
    set_req(0, 1'b1, mk_cmd(OP_PW, 8'd0, 3'd0, 1'b1), 64'h5555);
    to_neg();
    chk("drop_ready", 64'(u_if.host_req_ready), 64'b00);
    chk("drop_dvalid", 64'(u_if.dev_req_valid), 64'd1);
    to_pos();
    u_if.dev_req_ready = 1'b1;
    set_req(0, 1'b0, mk_cmd(OP_PW, 8'd0, 3'd0, 1'b1), 64'h5555);
    set_req(1, 1'b1, mk_cmd(OP_PW, 8'd0, 3'd0, 1'b1), 64'h6666);
    to_neg();
    chk("drop_next_ready", 64'(u_if.host_req_ready), 64'b10);
    chk("drop_next_busy", 64'(busy), 64'd0);
    to_pos();
    set_req(1, 1'b0, mk_cmd(OP_PW, 8'd0, 3'd0, 1'b1), 64'h6666);

    // Two-flit posted write by 1: REQ holds grant, then straight to IDLE.
    set_req(1, 1'b1, mk_cmd(OP_PW, 8'd0, 3'd0, 1'b0), 64'h7070);
    to_neg();
    chk("mf_ready0", 64'(u_if.host_req_ready), 64'b10);
    to_pos();
    set_req(1, 1'b1, mk_cmd(OP_PW, 8'd0, 3'd0, 1'b1), 64'h7777);
    set_req(0, 1'b1, mk_cmd(OP_PW, 8'd0, 3'd0, 1'b1), 64'h5555);
    to_neg();
    chk("mf_ready1", 64'(u_if.host_req_ready), 64'b10);
    chk("mf_owner", 64'(owner), 64'd1);
    chk("mf_busy", 64'(busy), 64'd1);
    chk("mf_data1", u_if.dev_req_data[63:0], 64'h7777);
    to_pos();
    set_req(1, 1'b0, mk_cmd(OP_PW, 8'd0, 3'd0, 1'b1), 64'h7777);
    to_neg();
    chk("mf_after_ready", 64'(u_if.host_req_ready), 64'b01);
    chk("mf_after_busy", 64'(busy), 64'd0);
    to_pos();
    set_req(0, 1'b0, mk_cmd(OP_PW, 8'd0, 3'd0, 1'b1), 64'h5555);

    // Reset while requester 1 is mid-packet in REQ.
    set_req(1, 1'b1, mk_cmd(OP_WR, 8'd0, 3'd0, 1'b0), 64'h8888);
    to_neg();
    chk("rq_ready", 64'(u_if.host_req_ready), 64'b10);
    to_pos();
    set_req(1, 1'b0, mk_cmd(OP_WR, 8'd0, 3'd0, 1'b0), 64'h8888);
    to_neg();
    chk("rq_stall_dvalid", 64'(u_if.dev_req_valid), 64'd0);
    chk("rq_stall_busy", 64'(busy), 64'd1);
    chk("rq_stall_owner", 64'(owner), 64'd1);
    to_pos();
    rst = 1'b1;
    u_if.host_req_valid = 2'b11;
    to_neg();
    chk("rq_rst_dvalid", 64'(u_if.dev_req_valid), 64'd0);
    chk("rq_rst_ready", 64'(u_if.host_req_ready), 64'b00);
    to_pos();
    rst = 1'b0;
    u_if.host_req_valid = 2'b00;
    to_neg();
    chk("rq_post_busy", 64'(busy), 64'd0);
    chk("rq_post_owner", 64'(owner), 64'd0);
    chk("rq_post_dvalid", 64'(u_if.dev_req_valid), 64'd0);
    chk("rq_post_ready", 64'(u_if.host_req_ready), 64'b00);
    chk("rq_post_hresp", 64'(u_if.host_resp_valid), 64'b00);
    to_pos();

`ifdef UMI_GPIO_ARB_TIMEOUT_EN
    // Read never answered: error pulse after 16 WAIT cycles, then 1 is granted.
    set_req(0, 1'b1, mk_cmd(OP_RD, 8'd0, 3'd0, 1'b1), 64'h9999);
    to_neg();
    chk("to_grant", 64'(u_if.host_req_ready), 64'b01);
    to_pos();
    set_req(0, 1'b0, mk_cmd(OP_RD, 8'd0, 3'd0, 1'b1), 64'h9999);
    set_req(1, 1'b1, mk_cmd(OP_PW, 8'd0, 3'd0, 1'b1), 64'hAAAA);
    for (int k = 0; k <= 16; k++) begin
      to_neg();
      chk($sformatf("to_err_%0d", k), 64'(timeout_err), 64'(k == 16));
      chk($sformatf("to_ready_%0d", k), 64'(u_if.host_req_ready), (k == 16) ? 64'b10 : 64'b00);
      to_pos();
    end
    set_req(1, 1'b0, mk_cmd(OP_PW, 8'd0, 3'd0, 1'b1), 64'hAAAA);
    to_neg();
    chk("to_err_clear", 64'(timeout_err), 64'd0);
    chk("to_busy", 64'(busy), 64'd0);
    chk("to_drain_ready", 64'(u_if.dev_resp_ready), 64'd1);
    to_pos();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
